instr_encoder: RTL and testbench

Sequential RISC-V RV64IM instruction encoder: accepts an `ariane_pkg::fu_op` plus register and immediate operands, and emits 32-bit instruction words with a PC over a valid/ready stream. It is the producer for the `decoder` instruction input, the inverse of the decoder mapping. It is used in the formal and simulation benches to generate legal decoder stimulus. It also expands the load-immediate pseudo-instruction into LUI+ADDIW.

---
 rtl/instr_encoder_pkg.sv | 77 +++++++
 rtl/instr_encode_comb.sv | 122 ++++++++++++
 rtl/instr_encoder.sv | 153 +++++++++++++++
 tb/tb_instr_encoder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared types and opcode constants for the RV64IM instruction encoder.
// Includes small field-packing helpers for the R/I/S/U formats.
package instr_encoder_pkg;

  typedef enum logic [7:0] {
    ADD, SUB, ADDW, SUBW,
    XORL, ORL, ANDL,
    SRA, SRL, SLL,
    SRLW, SLLW, SRAW,
    LTS, LTU, GES, GEU, EQ, NE,
    JALR, BRANCH,
    SLTS, SLTU,
    CSR_WRITE, CSR_READ,
    LD, SD, LW, LWU, SW,
    LH, LHU, SH, LB, SB, LBU,
    MUL, MULH, MULHU, MULHSU, MULW,
    DIV, DIVU, DIVW, DIVUW,
    REM, REMU, REMW, REMUW
  } fu_op;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    LI_HI,
    LI_LO
  } enc_state_t;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] LUI       = 7'b0110111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] r_type(
    input logic [6:0] f7,
    input logic [4:0] rs2,
    input logic [4:0] rs1,
    input logic [2:0] f3,
    input logic [4:0] rd,
    input logic [6:0] opc
  );
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] i_type(
    input logic [11:0] imm,
    input logic [4:0]  rs1,
    input logic [2:0]  f3,
    input logic [4:0]  rd,
    input logic [6:0]  opc
  );
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] s_type(
    input logic [11:0] imm,
    input logic [4:0]  rs2,
    input logic [4:0]  rs1,
    input logic [2:0]  f3,
    input logic [6:0]  opc
  );
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] u_type(
    input logic [19:0] imm,
    input logic [4:0]  rd,
    input logic [6:0]  opc
  );
    return {imm, rd, opc};
  endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// Combinational op/operand to 32-bit word mapping.
// supported_o low means the request has no legal encoding.
import instr_encoder_pkg::*;

module instr_encode_comb (
  input  fu_op        op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [11:0] imm_i,
  input  logic        use_imm_i,
  output logic [31:0] word_o,
  output logic        supported_o
);

  logic [2:0]  alu_f3;
  logic        alu_hit;
  logic [2:0]  mul_f3;
  logic        mul_hit;
  logic [2:0]  ld_f3;
  logic        ld_hit;
  logic [2:0]  st_f3;
  logic        st_hit;
  logic [6:0]  alu_f7;
  logic [11:0] shamt_imm;
  logic        is_shift;

  always_comb begin
    alu_f3  = 3'b000;
    alu_hit = 1'b1;
    unique case (op_i)
      ADD, SUB: alu_f3 = 3'b000;
      SLL:      alu_f3 = 3'b001;
      SLTS:     alu_f3 = 3'b010;
      SLTU:     alu_f3 = 3'b011;
      XORL:     alu_f3 = 3'b100;
      SRL, SRA: alu_f3 = 3'b101;
      ORL:      alu_f3 = 3'b110;
      ANDL:     alu_f3 = 3'b111;
      default:  alu_hit = 1'b0;
    endcase
  end

  always_comb begin
    mul_f3  = 3'b000;
    mul_hit = 1'b1;
    unique case (op_i)
      MUL:     mul_f3 = 3'b000;
      MULH:    mul_f3 = 3'b001;
      MULHSU:  mul_f3 = 3'b010;
      MULHU:   mul_f3 = 3'b011;
      DIV:     mul_f3 = 3'b100;
      DIVU:    mul_f3 = 3'b101;
      REM:     mul_f3 = 3'b110;
      REMU:    mul_f3 = 3'b111;
      default: mul_hit = 1'b0;
    endcase
  end

  always_comb begin
    ld_f3  = 3'b000;
    ld_hit = 1'b1;
    unique case (op_i)
      LB:      ld_f3 = 3'b000;
      LH:      ld_f3 = 3'b001;
      LW:      ld_f3 = 3'b010;
      LD:      ld_f3 = 3'b011;
      LBU:     ld_f3 = 3'b100;
      LHU:     ld_f3 = 3'b101;
      LWU:     ld_f3 = 3'b110;
      default: ld_hit = 1'b0;
    endcase
  end

  always_comb begin
    st_f3  = 3'b000;
    st_hit = 1'b1;
    unique case (op_i)
      SB:      st_f3 = 3'b000;
      SH:      st_f3 = 3'b001;
      SW:      st_f3 = 3'b010;
      SD:      st_f3 = 3'b011;
      default: st_hit = 1'b0;
    endcase
  end

  // RV64 shifts take a 6-bit shamt; bit 30 selects arithmetic
  always_comb begin
    is_shift  = (op_i == SLL) || (op_i == SRL) || (op_i == SRA);
    alu_f7    = ((op_i == SUB) || (op_i == SRA)) ? 7'b0100000 : 7'b0;
    shamt_imm = {1'b0, (op_i == SRA), 4'b0000, imm_i[5:0]};
  end

  always_comb begin
    word_o      = NOP_INSTR;
    supported_o = 1'b1;
    if (alu_hit) begin
      if (!use_imm_i)
        word_o = r_type(alu_f7, rs2_i, rs1_i, alu_f3, rd_i, OP);
      else if (op_i == SUB)
        supported_o = 1'b0;
      else if (is_shift)
        word_o = i_type(shamt_imm, rs1_i, alu_f3, rd_i, OP_IMM);
      else
        word_o = i_type(imm_i, rs1_i, alu_f3, rd_i, OP_IMM);
    end else if (mul_hit && !use_imm_i) begin
      word_o = r_type(7'b0000001, rs2_i, rs1_i, mul_f3, rd_i, OP);
    end else if (op_i == ADDW) begin
      if (use_imm_i)
        word_o = i_type(imm_i, rs1_i, 3'b000, rd_i, OP_IMM_32);
      else
        word_o = r_type(7'b0, rs2_i, rs1_i, 3'b000, rd_i, OP_32);
    end else if (ld_hit) begin
      word_o = i_type(imm_i, rs1_i, ld_f3, rd_i, LOAD);
    end else if (st_hit) begin
      word_o = s_type(imm_i, rs2_i, rs1_i, st_f3, STORE);
    end else begin
      supported_o = 1'b0;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV64IM encoder: request stream in, instruction words out.
// Owns the handshake FSM, PC, hand-off counter and LI split.
import instr_encoder_pkg::*;

module instr_encoder #(
  parameter logic [63:0] BOOT_ADDR = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  fu_op        req_op_i,
  input  logic [4:0]  req_rd_i,
  input  logic [4:0]  req_rs1_i,
  input  logic [4:0]  req_rs2_i,
  input  logic [31:0] req_imm_i,
  input  logic        req_use_imm_i,
  input  logic        req_li_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  output logic        unsupported_o,
  output logic [31:0] count_o
);

  enc_state_t  state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        unsup_q, unsup_d;

  logic [31:0] enc_word;
  logic        enc_ok;
  logic [19:0] li_hi;
  logic        hs;
  logic        accept;

  instr_encode_comb u_enc (
    .op_i        (req_op_i),
    .rd_i        (req_rd_i),
    .rs1_i       (req_rs1_i),
    .rs2_i       (req_rs2_i),
    .imm_i       (req_imm_i[11:0]),
    .use_imm_i   (req_use_imm_i),
    .word_o      (enc_word),
    .supported_o (enc_ok)
  );

  // ADDIW sign-extends imm[11:0], so round the upper part up
  assign li_hi = req_imm_i[31:12] + {19'b0, req_imm_i[11]};

  assign req_ready_o = !reset &&
    ((state_q == IDLE) ||
     ((state_q == SEND) && instr_ready_i));

  assign hs     = valid_q && instr_ready_i;
  assign accept = req_valid_i && req_ready_o;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    lo_d    = lo_q;
    pc_d    = pc_q;
    count_d = count_q;
    unsup_d = 1'b0;

    if (hs) begin
      pc_d    = pc_q + 64'd4;
      count_d = count_q + 32'd1;
    end

    unique case (state_q)
      IDLE: ;
      SEND: begin
        if (hs) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      LI_HI: begin
        if (hs) begin
          state_d = LI_LO;
          instr_d = lo_q;
        end
      end
      LI_LO: begin
        if (hs) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (accept) begin
      if (req_li_i) begin
        valid_d = 1'b1;
        if (li_hi != 20'd0) begin
          state_d = LI_HI;
          instr_d = u_type(li_hi, req_rd_i, LUI);
          lo_d    = i_type(req_imm_i[11:0], req_rd_i,
                           3'b000, req_rd_i, OP_IMM_32);
        end else begin
          state_d = SEND;
          instr_d = i_type(req_imm_i[11:0], 5'd0,
                           3'b000, req_rd_i, OP_IMM_32);
        end
      end else if (enc_ok) begin
        state_d = SEND;
        valid_d = 1'b1;
        instr_d = enc_word;
      end else begin
        state_d = IDLE;
        valid_d = 1'b0;
        unsup_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      lo_q    <= NOP_INSTR;
      pc_q    <= BOOT_ADDR;
      count_q <= 32'd0;
      unsup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      lo_q    <= lo_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      unsup_q <= unsup_d;
    end
  end

  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign count_o       = count_q;
  assign unsupported_o = unsup_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder.
// Expected words are queued on accept and checked at hand-off.
import instr_encoder_pkg::*;

module tb_instr_encoder;

  localparam logic [63:0] BOOT = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  fu_op        req_op_i;
  logic [4:0]  req_rd_i;
  logic [4:0]  req_rs1_i;
  logic [4:0]  req_rs2_i;
  logic [31:0] req_imm_i;
  logic        req_use_imm_i;
  logic        req_li_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic        unsupported_o;
  logic [31:0] count_o;

  instr_encoder #(.BOOT_ADDR(BOOT)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_rd_i      (req_rd_i),
    .req_rs1_i     (req_rs1_i),
    .req_rs2_i     (req_rs2_i),
    .req_imm_i     (req_imm_i),
    .req_use_imm_i (req_use_imm_i),
    .req_li_i      (req_li_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .unsupported_o (unsupported_o),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [63:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] exp_pc;
  int          n_pushed;
  int          n_cmp;
  int          n_err;
  int          cyc;
  int          last_acc;
  int          first_acc;
  bit          stalled;
  logic [31:0] held_w;
  logic [63:0] held_pc;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-off monitor: pop on handshake, check hold on stall
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", instr_valid_o, 1);
        check("hold_instr", instr_o, held_w);
        check("hold_pc", pc_o, held_pc);
      end
      if (instr_valid_o && instr_ready_i) begin
        if (sb_q.size() == 0) begin
          check("spurious_word", sb_q.size(), 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("instr", instr_o, e.w);
          check("pc", pc_o, e.pc);
        end
      end
      stalled = instr_valid_o && !instr_ready_i;
      held_w  = instr_o;
      held_pc = pc_o;
    end
  end

  task automatic push(input logic [31:0] w);
    exp_t e;
    e.w  = w;
    e.pc = exp_pc;
    sb_q.push_back(e);
    exp_pc = exp_pc + 64'd4;
    n_pushed++;
  endtask

  // Called at posedge+2; returns at posedge+2 after accept
  task automatic req(input fu_op op,
                     input logic [4:0] rd,
                     input logic [4:0] rs1,
                     input logic [4:0] rs2,
                     input logic [31:0] imm,
                     input logic use_imm,
                     input logic li,
                     input int nw,
                     input logic [31:0] w0,
                     input logic [31:0] w1);
    bit acc;
    bit rdy;
    acc           = 1'b0;
    req_op_i      = op;
    req_rd_i      = rd;
    req_rs1_i     = rs1;
    req_rs2_i     = rs2;
    req_imm_i     = imm;
    req_use_imm_i = use_imm;
    req_li_i      = li;
    req_valid_i   = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      rdy = req_ready_o;
      @(posedge clk);
      #2;
      if (rdy) acc = 1'b1;
    end
    req_valid_i = 1'b0;
    check("req_accept", acc, 1);
    if (acc && nw > 0) push(w0);
    if (acc && nw > 1) push(w1);
    last_acc = cyc;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++)
      @(negedge clk);
    check("drain", sb_q.size(), 0);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb_q.delete();
    exp_pc   = BOOT;
    n_pushed = 0;
  endtask

  task automatic chk_reset_vals();
    check("rst_valid", instr_valid_o, 0);
    check("rst_instr", instr_o, 32'h0000_0013);
    check("rst_pc", pc_o, BOOT);
    check("rst_count", count_o, 0);
    check("rst_unsup", unsupported_o, 0);
    check("rst_ready", req_ready_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    cyc           = 0;
    stalled       = 1'b0;
    req_valid_i   = 1'b0;
    req_op_i      = ADD;
    req_rd_i      = 5'd0;
    req_rs1_i     = 5'd0;
    req_rs2_i     = 5'd0;
    req_imm_i     = 32'd0;
    req_use_imm_i = 1'b0;
    req_li_i      = 1'b0;
    instr_ready_i = 1'b1;
    do_reset();
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #2;
    reset = 1'b0;

    // ADD x3,x1,x2
    req(ADD, 5'd3, 5'd1, 5'd2, 32'd0, 0, 0,
        1, 32'h002081B3, 0);
    drain();
    check("count_add", count_o, n_pushed);

    // LI x5,0x12345FFF splits into LUI+ADDIW
    req(ADD, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 0, 1,
        2, 32'h123462B7, 32'hFFF2829B);
    @(negedge clk);
    check("li_hi_ready", req_ready_o, 0);
    @(negedge clk);
    check("li_lo_ready", req_ready_o, 0);
    drain();

    // LI with hi == 0, and with hi wrapping to 0
    req(ADD, 5'd1, 5'd0, 5'd0, 32'h0000_07FF, 0, 1,
        1, 32'h7FF0009B, 0);
    req(ADD, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 0, 1,
        1, 32'h8000009B, 0);
    drain();
    check("count_li", count_o, n_pushed);

    // SD x2,8(x10) with consumer stalled 3 cycles
    instr_ready_i = 1'b0;
    req(SD, 5'd0, 5'd10, 5'd2, 32'd8, 1, 0,
        1, 32'h00253423, 0);
    repeat (3) @(posedge clk);
    #2;
    instr_ready_i = 1'b1;
    drain();
    check("pc_after_sd", pc_o, exp_pc);

    // Unsupported ops: no word, one-cycle pulse
    req(CSR_WRITE, 5'd1, 5'd2, 5'd3, 32'd0, 0, 0,
        0, 0, 0);
    @(negedge clk);
    check("unsup_pulse", unsupported_o, 1);
    check("unsup_novalid", instr_valid_o, 0);
    @(negedge clk);
    check("unsup_drop", unsupported_o, 0);
    check("unsup_count", count_o, n_pushed);
    @(posedge clk);
    #2;
    req(SUB, 5'd1, 5'd2, 5'd3, 32'd5, 1, 0,
        0, 0, 0);
    @(negedge clk);
    check("subi_unsup", unsupported_o, 1);
    check("subi_novalid", instr_valid_o, 0);
    @(posedge clk);
    #2;

    // Back-to-back words at full rate
    req(MUL, 5'd1, 5'd2, 5'd3, 32'd0, 0, 0,
        1, 32'h023100B3, 0);
    first_acc = last_acc;
    req(SRA, 5'd4, 5'd5, 5'd0, 32'd3, 1, 0,
        1, 32'h4032D213, 0);
    req(LW, 5'd6, 5'd7, 5'd0, 32'hFFFF_FFFC, 0, 0,
        1, 32'hFFC3A303, 0);
    req(ADDW, 5'd1, 5'd2, 5'd0, 32'd1, 1, 0,
        1, 32'h0011009B, 0);
    req(ADD, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1, 0,
        1, 32'hFFF00093, 0);
    req(ADD, 5'd3, 5'd1, 5'd2, 32'd0, 0, 0,
        1, 32'h002081B3, 0);
    check("throughput", last_acc - first_acc, 5);
    drain();
    check("count_burst", count_o, n_pushed);

    // Reset while the ADDIW half of an LI is pending
    instr_ready_i = 1'b0;
    req(ADD, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 0, 1,
        2, 32'h123462B7, 32'hFFF2829B);
    instr_ready_i = 1'b1;
    @(posedge clk);
    #2;
    instr_ready_i = 1'b0;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #2;
    reset = 1'b0;
    instr_ready_i = 1'b1;

    // PC restarts at BOOT after reset
    req(ADD, 5'd3, 5'd1, 5'd2, 32'd0, 0, 0,
        1, 32'h002081B3, 0);
    drain();
    check("count_post_rst", count_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
